// File: rtl/pc_sequencer.sv
// Program counter, status flags and FETCH/EXEC/HALT sequencing for the FRANK6000 core.
// Outputs decode from registered state only, so no input reaches an output combinationally.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_halt,
  input  logic                i_jump_en,
  input  logic                i_jump,
  input  logic [PC_WIDTH-1:0] i_target,
  input  logic                i_flags_we,
  input  logic [2:0]          i_flags,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_fetch,
  output logic                o_exec,
  output logic [2:0]          o_status,
  output logic                o_halted
);

  localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_ADDR);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc, pc_next;
  logic [2:0]          status, status_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      status <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      status <= status_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    status_next = status;
    case (state)
      FETCH: begin
        if (i_enable) state_next = EXEC;
      end
      EXEC: begin
        if (i_enable) begin
          // Halt wins over both the PC update and the flag write.
          if (i_halt) begin
            state_next = HALT;
          end else begin
            state_next = FETCH;
            if (i_jump_en && i_jump) pc_next = i_target;
            else                     pc_next = pc + PC_WIDTH'(1);
            if (i_flags_we) status_next = i_flags;
          end
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  assign o_pc     = pc;
  assign o_status = status;
  assign o_fetch  = (state == FETCH);
  assign o_exec   = (state == EXEC);
  assign o_halted = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against an instruction-level reference model.
module tb_pc_sequencer;

  logic       i_clk;
  logic       i_reset;
  logic       i_enable;
  logic       i_halt;
  logic       i_jump_en;
  logic       i_jump;
  logic [7:0] i_target;
  logic       i_flags_we;
  logic [2:0] i_flags;
  logic [7:0] o_pc;
  logic       o_fetch;
  logic       o_exec;
  logic [2:0] o_status;
  logic       o_halted;

  pc_sequencer #(.PC_WIDTH(8), .RESET_ADDR(0)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_halt     (i_halt),
    .i_jump_en  (i_jump_en),
    .i_jump     (i_jump),
    .i_target   (i_target),
    .i_flags_we (i_flags_we),
    .i_flags    (i_flags),
    .o_pc       (o_pc),
    .o_fetch    (o_fetch),
    .o_exec     (o_exec),
    .o_status   (o_status),
    .o_halted   (o_halted)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference model: which half of the instruction we are in, whether halted, PC and flags.
  int         m_pc;
  logic [2:0] m_flags;
  bit         m_exec;
  bit         m_halted;

  int n_vec = 0;
  int n_err = 0;

  logic [13:0] obs;
  assign obs = {o_pc, o_fetch, o_exec, o_halted, o_status};

  function automatic logic [13:0] exp_vec();
    logic [7:0] p;
    p = m_pc[7:0];
    return {p, (!m_halted && !m_exec), (!m_halted && m_exec), m_halted, m_flags};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_flags = 3'b000; m_exec = 0; m_halted = 0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, sample 1 ns later.
  task automatic step(input bit en, input bit hlt, input bit jen, input bit jmp,
                      input logic [7:0] tgt, input bit fwe, input logic [2:0] fl);
    i_enable = en; i_halt = hlt; i_jump_en = jen; i_jump = jmp;
    i_target = tgt; i_flags_we = fwe; i_flags = fl;
    @(posedge i_clk);
    if (en && !m_halted) begin
      if (!m_exec) m_exec = 1;
      else if (hlt) m_halted = 1;
      else begin
        if (jen && jmp) m_pc = tgt;
        else            m_pc = (m_pc + 1) % 256;
        if (fwe) m_flags = fl;
        m_exec = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 8'h00, 0, 3'b000);
  endtask

  task automatic jump_to(input logic [7:0] t);
    if (!m_exec) idle();
    step(1, 0, 1, 1, t, 0, 3'b000);
  endtask

  task automatic rand_step();
    step(($urandom_range(0, 7) != 0), ($urandom_range(0, 47) == 0),
         bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
         8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
         3'($urandom_range(0, 7)));
  endtask

  // Asserts reset between clock edges; caller checks, then calls release_reset.
  task automatic assert_reset();
    #2 i_reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL reset_initial: got %h want %h", obs, exp_vec());
    end
    release_reset();
    repeat (5) idle();
    assert_reset();
    n_vec++;
    if (o_pc !== 8'h00 || o_fetch !== 1'b1 || o_exec !== 1'b0 || o_halted !== 1'b0 || o_status !== 3'b000) begin
      n_err++; $display("FAIL reset_mid_exec: got %h want %h", obs, {8'h00, 3'b100, 3'b000});
    end
    release_reset();
    n_vec++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL reset_release: got %h want %h", obs, exp_vec());
    end
    for (int i = 0; i < 12; i++) begin
      idle();
      n_vec++;
      if (obs !== exp_vec() || o_pc !== 8'((i + 1) / 2)) begin
        n_err++; $display("FAIL seq_run[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    jump_to(8'hFD);
    for (int i = 0; i < 8; i++) begin
      idle();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL wrap[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
    n_vec++;
    if (o_pc !== 8'h01 || o_halted !== 1'b0) begin
      n_err++; $display("FAIL wrap_end: got pc %h halted %b want pc 01 halted 0", o_pc, o_halted);
    end
  endtask

  task automatic test_jump();
    jump_to(8'h05);
    idle();
    step(1, 0, 1, 1, 8'h3A, 0, 3'b000);
    n_vec++;
    if (obs !== exp_vec() || o_pc !== 8'h3A || o_fetch !== 1'b1) begin
      n_err++; $display("FAIL jump_taken: got %h want %h", obs, exp_vec());
    end
    idle();
    step(1, 0, 1, 0, 8'h99, 0, 3'b000);
    n_vec++;
    if (obs !== exp_vec() || o_pc !== 8'h3B) begin
      n_err++; $display("FAIL jump_not_taken: got %h want %h", obs, exp_vec());
    end
    idle();
    step(1, 0, 0, 1, 8'h77, 0, 3'b000);
    n_vec++;
    if (obs !== exp_vec() || o_pc !== 8'h3C) begin
      n_err++; $display("FAIL jump_en_low: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_flag_jump();
    assert_reset();
    release_reset();
    idle();
    step(1, 0, 1, 1, 8'h10, 1, 3'b001);
    n_vec++;
    if (obs !== exp_vec() || o_pc !== 8'h10 || o_status !== 3'b001) begin
      n_err++; $display("FAIL flag_jump: got %h want %h", obs, exp_vec());
    end
    idle();
    step(1, 0, 0, 0, 8'h00, 0, 3'b110);
    n_vec++;
    if (obs !== exp_vec() || o_status !== 3'b001 || o_pc !== 8'h11) begin
      n_err++; $display("FAIL flag_hold: got %h want %h", obs, exp_vec());
    end
    step(1, 1, 1, 1, 8'hAA, 1, 3'b111);
    n_vec++;
    if (obs !== exp_vec() || o_exec !== 1'b1 || o_pc !== 8'h11 || o_status !== 3'b001) begin
      n_err++; $display("FAIL fetch_ignores_inputs: got %h want %h", obs, exp_vec());
    end
    step(1, 0, 0, 0, 8'h00, 0, 3'b000);
  endtask

  task automatic test_stall();
    step(0, 0, 0, 0, 8'h00, 0, 3'b000);
    n_vec++;
    if (obs !== exp_vec() || o_fetch !== 1'b1) begin
      n_err++; $display("FAIL stall_fetch: got %h want %h", obs, exp_vec());
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 8'h22, 1, 3'b100);
      n_vec++;
      if (obs !== exp_vec() || o_exec !== 1'b1 || o_pc === 8'h22) begin
        n_err++; $display("FAIL stall_exec[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
    step(1, 0, 1, 1, 8'h22, 1, 3'b100);
    n_vec++;
    if (obs !== exp_vec() || o_pc !== 8'h22 || o_status !== 3'b100) begin
      n_err++; $display("FAIL stall_release: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_halt();
    if (!m_exec) idle();
    step(1, 0, 1, 1, 8'h07, 1, 3'b010);
    idle();
    step(1, 1, 1, 1, 8'h55, 1, 3'b111);
    n_vec++;
    if (obs !== exp_vec() || o_halted !== 1'b1 || o_pc !== 8'h07 || o_status !== 3'b010) begin
      n_err++; $display("FAIL halt_enter: got %h want %h", obs, exp_vec());
    end
    for (int i = 0; i < 16; i++) begin
      rand_step();
      n_vec++;
      if (obs !== exp_vec() || o_halted !== 1'b1 || o_pc !== 8'h07) begin
        n_err++; $display("FAIL halt_absorb[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
    assert_reset();
    n_vec++;
    if (obs !== exp_vec() || o_fetch !== 1'b1 || o_pc !== 8'h00) begin
      n_err++; $display("FAIL halt_reset: got %h want %h", obs, exp_vec());
    end
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        assert_reset();
        release_reset();
      end else begin
        rand_step();
      end
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_halt = 1'b0; i_jump_en = 1'b0; i_jump = 1'b0;
    i_target = 8'h00; i_flags_we = 1'b0; i_flags = 3'b000;
    model_reset();
    test_reset();
    test_wrap();
    test_jump();
    test_flag_jump();
    test_stall();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
